// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: pops a one-hot mole, times it, scores hits
// from debounced buttons and ends the game after MAX_MISSES timeouts.
module mole_game_ctrl #(
  parameter int          TICK_DIV   = 100000,
  parameter int          UP_MS      = 1000,
  parameter int          GAP_MS     = 300,
  parameter int          MAX_MISSES = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       in_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] btn,
  output logic [7:0] holes,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [2:0] dbg_state
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX = (UP_MS > GAP_MS) ? UP_MS : GAP_MS;
  localparam int MS_W   = ($clog2(MS_MAX + 1) > 10) ? $clog2(MS_MAX + 1) : 10;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  UP_LAST    = MS_W'(UP_MS - 1);
  localparam logic [MS_W-1:0]  GAP_LAST   = MS_W'(GAP_MS - 1);
  localparam logic [2:0]       MISS_LIMIT = 3'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_UP    = 3'd2,
    S_GAP   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [15:0]      lfsr_q;
  logic             lfsr_fb;
  logic [7:0]       s1_q, s2_q, s3_q;
  logic [7:0]       bedge;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       cand, spawn_idx;
  logic [7:0]       holes_q, holes_d;
  logic [7:0]       score_q, score_d;
  logic [2:0]       misses_q, misses_d, misses_inc;
  logic             game_over_q, game_over_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  // Free-running divider; intervals after a state entry may be up to one tick short.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge in_clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign bedge = s2_q & ~s3_q;

  // x^16 + x^14 + x^13 + x^11 + 1; a nonzero seed can never reach zero.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge in_clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign cand       = lfsr_q[2:0];
  assign spawn_idx  = (cand == prev_q) ? cand + 3'd1 : cand;
  assign misses_inc = misses_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    holes_d     = holes_q;
    score_d     = score_q;
    misses_d    = misses_q;
    game_over_d = game_over_q;
    prev_d      = prev_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        holes_d = 8'h00;
        if (start) begin
          score_d  = 8'h00;
          misses_d = 3'd0;
          state_d  = S_SPAWN;
        end
      end
      S_SPAWN: begin
        prev_d  = spawn_idx;
        holes_d = 8'd1 << spawn_idx;
        state_d = S_UP;
      end
      S_UP: begin
        // A hit beats a timeout landing in the same cycle.
        if (bedge[prev_q]) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          hit_d   = 1'b1;
          holes_d = 8'h00;
          state_d = S_GAP;
        end else if (tick && (ms_q == UP_LAST)) begin
          misses_d = misses_inc;
          miss_d   = 1'b1;
          if (misses_inc == MISS_LIMIT) begin
            holes_d     = 8'hFF;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else begin
            holes_d = 8'h00;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        holes_d = 8'h00;
        if (tick && (ms_q == GAP_LAST)) begin
          state_d = S_SPAWN;
        end
      end
      S_OVER: begin
        holes_d     = 8'hFF;
        game_over_d = 1'b1;
        if (start) begin
          score_d     = 8'h00;
          misses_d    = 3'd0;
          game_over_d = 1'b0;
          holes_d     = 8'h00;
          state_d     = S_SPAWN;
        end
      end
      default: begin
        holes_d     = 8'h00;
        game_over_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ms_d = ms_q;
    if (state_d != state_q) begin
      ms_d = '0;
    end else if (tick) begin
      ms_d = ms_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ms_q        <= '0;
      prev_q      <= 3'd0;
      holes_q     <= 8'h00;
      score_q     <= 8'h00;
      misses_q    <= 3'd0;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_q        <= ms_d;
      prev_q      <= prev_d;
      holes_q     <= holes_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign holes      = holes_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign game_over  = game_over_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign dbg_state  = state_q;

endmodule
